// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - serial packed-BCD adder, one shared 4-bit CLA for add and +6 correction
// Optional invalid-digit flag built only when BCD_CHECK_EN is defined.

module cla_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      s    = p ^ c[3:0];
      cout = c[4];
   end
endmodule

module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, ADD, CORR, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [W-1:0]    acc_q, acc_d, sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [3:0]      z_q, z_d;
   logic            carry_q, carry_d;
   logic            busy_q, busy_d, done_q, done_d, cout_q, cout_d;
   logic            advance;

   logic [3:0]      a_dig, b_dig, cla_a, cla_b, cla_s;
   logic            cla_cin, cla_co;

   assign a_dig = a_q[{idx_q, 2'b00} +: 4];
   assign b_dig = b_q[{idx_q, 2'b00} +: 4];

   // The one adder is time-shared: binary digit add in ADD, +6 fix-up in CORR.
   assign cla_a   = (state_q == CORR) ? z_q     : a_dig;
   assign cla_b   = (state_q == CORR) ? 4'b0110 : b_dig;
   assign cla_cin = (state_q == CORR) ? 1'b0    : carry_q;

   cla_4bit u_cla (
      .a    (cla_a),
      .b    (cla_b),
      .cin  (cla_cin),
      .s    (cla_s),
      .cout (cla_co)
   );

`ifdef BCD_CHECK_EN
   logic err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      z_d     = z_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;
      advance = 1'b0;
`ifdef BCD_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ADD;
`ifdef BCD_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         ADD: begin
`ifdef BCD_CHECK_EN
            if (a_dig > 4'd9 || b_dig > 4'd9) err_d = 1'b1;
`endif
            // Raw digit sum above 9 needs the +6 fix-up pass.
            if (cla_co | (cla_s[3] & (cla_s[2] | cla_s[1]))) begin
               z_d     = cla_s;
               state_d = CORR;
            end else begin
               acc_d[{idx_q, 2'b00} +: 4] = cla_s;
               carry_d = 1'b0;
               advance = 1'b1;
            end
         end
         CORR: begin
            acc_d[{idx_q, 2'b00} +: 4] = cla_s;
            carry_d = 1'b1;
            advance = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (idx_q == IW'(DIGITS - 1)) begin
            sum_d   = acc_d;
            cout_d  = carry_d;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ADD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         z_q     <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
`ifdef BCD_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         z_q     <= z_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
`ifdef BCD_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - randomized self-checking bench for bcd_serial_add_ctrl
`timescale 1ns/1ps

module tb_bcd_serial_add_ctrl;
   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [W-1:0] a, b, sum;
   logic         busy, done, cout, err;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] last_sum;
   logic         last_cout;
   logic         last_err;

   always #50 clk = ~clk;

   bcd_serial_add_ctrl #(.DIGITS(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal digit-by-digit addition straight from the digit rules.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                        output logic [W-1:0] ms, output logic mco, output int nc, output logic me);
      int c, ad, bd, z, dig;
      c  = int'(mci);
      nc = 0;
      ms = '0;
      me = 1'b0;
      for (int i = 0; i < D; i++) begin
         ad = int'((ma >> (4 * i)) & 16'hF);
         bd = int'((mb >> (4 * i)) & 16'hF);
         if (ad > 9 || bd > 9) me = 1'b1;
         z = ad + bd + c;
         if (z > 9) begin
            dig = (z + 6) % 16;
            c   = 1;
            nc++;
         end else begin
            dig = z;
            c   = 0;
         end
         ms = ms | (W'(dig) << (4 * i));
      end
      mco = (c != 0);
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ci,
                         input int inject, input string tag);
      logic [W-1:0] es;
      logic         eco, ee, exp_err;
      int           nc, lat, busy_n;
      model(ta, tb_v, ci, es, eco, nc, ee);
`ifdef BCD_CHECK_EN
      exp_err = ee;
`else
      exp_err = 1'b0;
`endif
      @(negedge clk);
      a = ta; b = tb_v; cin = ci; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busy_n = 0;
      lat = -1;
      check({tag, "_sum_hold"}, 32'(sum), 32'(last_sum));
      check({tag, "_cout_hold"}, 32'(cout), 32'(last_cout));
      if (busy) busy_n++;
      for (int k = 1; k <= 3 * D + 2 && lat < 0; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) lat = k;
         else if (busy) busy_n++;
         if (k == inject) begin
            start = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
         end
      end
      if (lat < 0) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_latency"}, 32'(lat), 32'(D + nc));
         check({tag, "_busy_cycles"}, 32'(busy_n), 32'(D + nc));
         check({tag, "_sum"}, 32'(sum), 32'(es));
         check({tag, "_cout"}, 32'(cout), 32'(eco));
         check({tag, "_err"}, 32'(err), 32'(exp_err));
         // A start during the DONE cycle must be ignored.
         start = 1'b1;
         a = W'($urandom);
         @(posedge clk);
         #1;
         start = 1'b0;
         check({tag, "_done_pulse"}, 32'(done), 32'd0);
         check({tag, "_idle_busy"}, 32'(busy), 32'd0);
         @(posedge clk);
         #1;
         check({tag, "_idle_busy2"}, 32'(busy), 32'd0);
         check({tag, "_err_sticky"}, 32'(err), 32'(exp_err));
         check({tag, "_sum_keep"}, 32'(sum), 32'(es));
      end
      last_sum  = es;
      last_cout = eco;
      last_err  = exp_err;
   endtask

   initial begin
      int pulses;
      logic [W-1:0] ra, rb;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      last_sum = '0; last_cout = 1'b0; last_err = 1'b0;

      run_op(16'h1234, 16'h4321, 1'b0, -1, "plain");
      run_op(16'h9999, 16'h0001, 1'b0, -1, "ripple");
      run_op(16'h0999, 16'h0000, 1'b1, -1, "carry_in");
      run_op(16'h0005, 16'h0005, 1'b0, -1, "five");
      run_op(16'h9999, 16'h9999, 1'b0, 2, "ignored_start");
      run_op(16'h00A0, 16'h0000, 1'b0, -1, "invalid");
      repeat (3) @(posedge clk);
      #1;
      check("err_still_sticky", 32'(err), 32'(last_err));
      run_op(16'h0012, 16'h0034, 1'b0, -1, "err_clear");

      // Reset in the middle of an operation discards everything.
      @(negedge clk);
      a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) pulses++;
         @(posedge clk);
         #1;
      end
      check("midrst_no_done", 32'(pulses), 32'd0);
      last_sum = '0; last_cout = 1'b0; last_err = 1'b0;

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            ra = W'($urandom);
            rb = W'($urandom);
         end else begin
            for (int i = 0; i < D; i++) begin
               ra[4*i +: 4] = 4'($urandom_range(0, 9));
               rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
         end
         run_op(ra, rb, 1'($urandom), -1, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
